// File: rtl/gpu_cmd_queue.sv
// gpu_cmd_queue
//   Buffers draw/clear commands for a framebuffer GPU and issues them one at a
//   time over a parameter bus plus a one-cycle command strobe.
//
//   Ports
//     clk, rstn            clock, asynchronous active-low reset
//     cmd_valid/cmd_ready  command handshake (accept when both high)
//     cmd_clear            command type: 0 = draw, 1 = clear
//     cmd_*                command fields (address, source offsets, image
//                          width, excerpt size, screen position, clear colour)
//     flush                drop every queued command that has not been issued
//     gpu_busy             GPU busy flag
//     ctrl_*               parameter bus to the GPU, held from issue until the
//                          command retires and afterwards until the next issue
//     ctrl_draw/ctrl_clear one-cycle command strobes
//     count                queued entries, including the one being executed
//     idle                 queue empty and no command executing
//     timeout_err          sticky: the GPU never acknowledged a command
module gpu_cmd_queue #(
    parameter int FB_WIDTH     = 400,
    parameter int FB_HEIGHT    = 240,
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_clear,
    input  logic [31:0]                   cmd_address,
    input  logic [15:0]                   cmd_address_x,
    input  logic [15:0]                   cmd_address_y,
    input  logic [15:0]                   cmd_image_width,
    input  logic [$clog2(FB_WIDTH)+1:0]   cmd_width,
    input  logic [$clog2(FB_WIDTH)+1:0]   cmd_x,
    input  logic [$clog2(FB_HEIGHT)+1:0]  cmd_height,
    input  logic [$clog2(FB_HEIGHT)+1:0]  cmd_y,
    input  logic [15:0]                   cmd_clear_color,
    input  logic                          flush,
    input  logic                          gpu_busy,
    output logic [31:0]                   ctrl_address,
    output logic [15:0]                   ctrl_address_x,
    output logic [15:0]                   ctrl_address_y,
    output logic [15:0]                   ctrl_image_width,
    output logic [$clog2(FB_WIDTH)+1:0]   ctrl_width,
    output logic [$clog2(FB_WIDTH)+1:0]   ctrl_x,
    output logic [$clog2(FB_HEIGHT)+1:0]  ctrl_height,
    output logic [$clog2(FB_HEIGHT)+1:0]  ctrl_y,
    output logic [15:0]                   ctrl_clear_color,
    output logic                          ctrl_draw,
    output logic                          ctrl_clear,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          idle,
    output logic                          timeout_err
);

    localparam int W  = $clog2(FB_WIDTH) + 2;
    localparam int H  = $clog2(FB_HEIGHT) + 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(BUSY_TIMEOUT - 1);

    typedef struct packed {
        logic          clr;
        logic [31:0]   address;
        logic [15:0]   address_x;
        logic [15:0]   address_y;
        logic [15:0]   image_width;
        logic [W-1:0]  width;
        logic [W-1:0]  x;
        logic [H-1:0]  height;
        logic [H-1:0]  y;
        logic [15:0]   clear_color;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAIT_BUSY, WAIT_DONE} state_t;

    cmd_t            mem [DEPTH];
    cmd_t            cmd_in;
    cmd_t            ctrl_q;
    state_t          state;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TW-1:0]   tcnt;
    logic            push;
    logic            pop;
    logic            in_flight;

    assign cmd_in = {cmd_clear, cmd_address, cmd_address_x, cmd_address_y,
                     cmd_image_width, cmd_width, cmd_x, cmd_height, cmd_y,
                     cmd_clear_color};

    // Ready depends on count alone, so a retiring entry never frees a slot
    // for a push in the same cycle.
    assign cmd_ready = (count < CW'(DEPTH));
    // A flush wins over a coincident push.
    assign push      = cmd_valid && cmd_ready && !flush;
    // The head stays in the FIFO while it executes and leaves when the GPU
    // drops busy.
    assign pop       = (state == WAIT_DONE) && !gpu_busy;
    assign in_flight = (state != IDLE);
    assign idle      = (count == '0) && (state == IDLE);

    assign ctrl_address     = ctrl_q.address;
    assign ctrl_address_x   = ctrl_q.address_x;
    assign ctrl_address_y   = ctrl_q.address_y;
    assign ctrl_image_width = ctrl_q.image_width;
    assign ctrl_width       = ctrl_q.width;
    assign ctrl_x           = ctrl_q.x;
    assign ctrl_height      = ctrl_q.height;
    assign ctrl_y           = ctrl_q.y;
    assign ctrl_clear_color = ctrl_q.clear_color;

    // Command storage carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (flush) begin
                // Keep only the executing head, if any; it retires normally.
                wr_ptr <= in_flight ? rd_ptr + PW'(1) : rd_ptr;
                count  <= (in_flight && !pop) ? CW'(1) : '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Issue sequencer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            ctrl_q      <= '0;
            ctrl_draw   <= 1'b0;
            ctrl_clear  <= 1'b0;
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((count != '0) && !gpu_busy && !flush) begin
                        ctrl_q <= mem[rd_ptr];
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    ctrl_draw  <= !ctrl_q.clr;
                    ctrl_clear <= ctrl_q.clr;
                    state      <= PULSE;
                end
                PULSE: begin
                    ctrl_draw  <= 1'b0;
                    ctrl_clear <= 1'b0;
                    // The strobe cycle counts towards the busy timeout.
                    tcnt       <= TW'(1);
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (gpu_busy) begin
                        state <= WAIT_DONE;
                    end else if (tcnt >= TLIM) begin
                        timeout_err <= 1'b1;
                        state       <= WAIT_DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!gpu_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Testbench for gpu_cmd_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model and a strobe scoreboard.
module tb_gpu_cmd_queue;

    localparam int DEPTH = 4;
    localparam int BT    = 4;
    localparam int WW    = 11;
    localparam int HW    = 10;

    typedef struct packed {
        logic           clr;
        logic [31:0]    address;
        logic [15:0]    ax;
        logic [15:0]    ay;
        logic [15:0]    iw;
        logic [WW-1:0]  width;
        logic [WW-1:0]  x;
        logic [HW-1:0]  height;
        logic [HW-1:0]  y;
        logic [15:0]    color;
    } cmd_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic cmd_valid = 1'b0;
    logic flush = 1'b0;
    logic ext_busy = 1'b0;
    logic gpu_int = 1'b0;
    logic gpu_busy;
    cmd_t drv = '0;

    logic              cmd_ready;
    logic [31:0]       ctrl_address;
    logic [15:0]       ctrl_address_x, ctrl_address_y, ctrl_image_width;
    logic [WW-1:0]     ctrl_width, ctrl_x;
    logic [HW-1:0]     ctrl_height, ctrl_y;
    logic [15:0]       ctrl_clear_color;
    logic              ctrl_draw, ctrl_clear;
    logic [2:0]        count;
    logic              idle, timeout_err;
    logic [137:0]      dut_fields;

    int checks = 0;
    int failures = 0;

    assign gpu_busy   = ext_busy | gpu_int;
    assign dut_fields = {ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
                         ctrl_width, ctrl_x, ctrl_height, ctrl_y, ctrl_clear_color};

    gpu_cmd_queue #(
        .FB_WIDTH(400), .FB_HEIGHT(240), .DEPTH(DEPTH), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(drv.clr),
        .cmd_address(drv.address), .cmd_address_x(drv.ax), .cmd_address_y(drv.ay),
        .cmd_image_width(drv.iw), .cmd_width(drv.width), .cmd_x(drv.x),
        .cmd_height(drv.height), .cmd_y(drv.y), .cmd_clear_color(drv.color),
        .flush(flush), .gpu_busy(gpu_busy),
        .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x),
        .ctrl_address_y(ctrl_address_y), .ctrl_image_width(ctrl_image_width),
        .ctrl_width(ctrl_width), .ctrl_x(ctrl_x), .ctrl_height(ctrl_height),
        .ctrl_y(ctrl_y), .ctrl_clear_color(ctrl_clear_color),
        .ctrl_draw(ctrl_draw), .ctrl_clear(ctrl_clear),
        .count(count), .idle(idle), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (advances on each clock edge) ----------
    cmd_t exp_q[$];       // commands held by the queue, oldest first
    cmd_t sb_q[$];        // accepted commands still waiting for their strobe
    bit   eng = 0;        // a command is being executed
    bit   acked = 0;      // GPU acknowledged (or timed out) the current command
    bit   sb_pending = 0; // current command's strobe not yet observed
    bit   exp_err = 0;
    int   st_edges = 0;   // clock edges since execution started
    cmd_t shown = '0;     // values the parameter bus must show

    always @(posedge clk or negedge rstn) begin
        int  sz;
        int  n;
        bit  start;
        bit  acc;
        bit  retire;
        if (!rstn) begin
            exp_q.delete();
            sb_q.delete();
            eng = 0; acked = 0; sb_pending = 0; exp_err = 0; st_edges = 0;
            shown = '0;
        end else begin
            sz     = exp_q.size();
            start  = !eng && sz > 0 && !gpu_busy && !flush;
            acc    = cmd_valid && sz < DEPTH && !flush;
            retire = 0;
            if (eng) begin
                n = st_edges + 1;
                // Strobe rises on edge 1; busy is watched from edge 3 and the
                // timeout fires BT edges after the strobe edge.
                if (acked) retire = !gpu_busy;
                else if (n >= 3) begin
                    if (gpu_busy) acked = 1;
                    else if (n == BT + 1) begin
                        acked = 1;
                        exp_err = 1;
                    end
                end
                st_edges = n;
            end
            if (retire) begin
                void'(exp_q.pop_front());
                eng = 0;
                acked = 0;
            end
            if (flush) begin
                if (eng) begin
                    while (exp_q.size() > 1) void'(exp_q.pop_back());
                end else exp_q.delete();
                if (eng && sb_pending) begin
                    while (sb_q.size() > 1) void'(sb_q.pop_back());
                end else sb_q.delete();
            end
            if (acc) begin
                exp_q.push_back(drv);
                sb_q.push_back(drv);
            end
            if (start) begin
                eng = 1;
                st_edges = 0;
                acked = 0;
                shown = exp_q[0];
                sb_pending = 1;
            end
        end
    end

    // ---------------- monitor --------------------------------------------------
    always @(negedge clk) begin
        bit   es;
        cmd_t e;
        es = eng && (st_edges == 1);
        chk("count", count, exp_q.size());
        chk("cmd_ready", cmd_ready, exp_q.size() < DEPTH);
        chk("idle", idle, (exp_q.size() == 0) && !eng);
        chk("timeout_err", timeout_err, exp_err);
        chk("ctrl_draw", ctrl_draw, es && !shown.clr);
        chk("ctrl_clear", ctrl_clear, es && shown.clr);
        chk("ctrl_fields", dut_fields, shown[137:0]);
        if (ctrl_draw || ctrl_clear) begin
            if (sb_q.size() == 0) chk("sb_unexpected_strobe", 1'b1, 1'b0);
            else begin
                e = sb_q.pop_front();
                sb_pending = 0;
                chk("sb_type", {ctrl_draw, ctrl_clear}, {!e.clr, e.clr});
                chk("sb_fields", dut_fields, e[137:0]);
            end
        end
    end

    // ---------------- GPU model -----------------------------------------------
    int lat = 4;
    int bcnt = 0;
    bit never_busy = 0;

    always @(negedge clk) begin
        if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) gpu_int = 1'b0;
        end
        if ((ctrl_draw || ctrl_clear) && !never_busy) begin
            gpu_int = 1'b1;
            bcnt = lat;
        end
    end

    // ---------------- stimulus --------------------------------------------------
    function automatic cmd_t rand_cmd();
        cmd_t r;
        r.clr     = 1'($urandom_range(0, 1));
        r.address = $urandom();
        r.ax      = 16'($urandom());
        r.ay      = 16'($urandom());
        r.iw      = 16'($urandom());
        r.width   = WW'($urandom());
        r.x       = WW'($urandom());
        r.height  = HW'($urandom());
        r.y       = HW'($urandom());
        r.color   = 16'($urandom());
        return r;
    endfunction

    task automatic drive_push(input cmd_t c);
        drv = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        int k;
        k = 0;
        while (idle !== 1'b1 && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(name, idle, 1'b1);
    endtask

    cmd_t c;

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Single draw with a long GPU job.
        c = '0;
        c.address = 32'h1000; c.x = 10; c.y = 20; c.width = 16; c.height = 8;
        lat = 128;
        drive_push(c);
        wait_idle(200, "single_draw_idle");

        // Clear command.
        c = '0;
        c.clr = 1'b1; c.color = 16'hF801;
        lat = 6;
        drive_push(c);
        wait_idle(60, "clear_idle");

        // Fill with the GPU held busy: only DEPTH commands fit.
        ext_busy = 1'b1;
        for (int i = 0; i < 5; i++) drive_push(rand_cmd());
        chk("fill_ready", cmd_ready, 1'b0);
        chk("fill_count", count, 3'd4);
        repeat (3) @(negedge clk);
        ext_busy = 1'b0;
        lat = 3;
        wait_idle(200, "fill_drain_idle");

        // Flush with a simultaneous push while the head is executing.
        lat = 30;
        for (int i = 0; i < 3; i++) drive_push(rand_cmd());
        repeat (6) @(negedge clk);
        drv = rand_cmd();
        cmd_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        flush = 1'b0;
        chk("flush_count", count, 3'd1);
        wait_idle(100, "flush_idle");
        repeat (5) @(negedge clk);

        // GPU never raises busy.
        never_busy = 1'b1;
        drive_push(rand_cmd());
        drive_push(rand_cmd());
        wait_idle(100, "timeout_idle");
        chk("timeout_sticky", timeout_err, 1'b1);
        never_busy = 1'b0;

        // Reset while the GPU is busy executing a command.
        lat = 40;
        drive_push(rand_cmd());
        repeat (8) @(negedge clk);
        ext_busy = 1'b1;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst_draw", ctrl_draw, 1'b0);
        chk("rst_clear", ctrl_clear, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_fields", dut_fields, 138'd0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        drive_push(rand_cmd());
        repeat (10) @(negedge clk);
        ext_busy = 1'b0;
        wait_idle(150, "post_reset_idle");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drv = rand_cmd();
            cmd_valid = ($urandom_range(0, 99) < 55);
            flush = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 5) ext_busy = ~ext_busy;
            lat = $urandom_range(2, 8);
            never_busy = ($urandom_range(0, 99) < 10);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        flush = 1'b0;
        ext_busy = 1'b0;
        never_busy = 1'b0;
        wait_idle(400, "random_drain_idle");
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/gpu_cmd_queue.md
GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

Interface
REQ-001 SHALL have parameters: FB_WIDTH, default 400, framebuffer width; FB_HEIGHT, default 240, framebuffer height; DEPTH, default 4, command slots (power of 2); BUSY_TIMEOUT, default 4, max cycles to wait for GPU busy.
REQ-002 SHALL have these ports, one clock, reset asynchronous active-low:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  requester offers a command
- cmd_ready  out  1  queue can accept
- cmd_clear  in  1  0 = draw, 1 = clear
- cmd_address  in  32  image base address
- cmd_address_x, cmd_address_y, cmd_image_width  in  16 each  source offsets and image width
- cmd_width, cmd_x  in  W = clog2(FB_WIDTH)+2 (11)  excerpt width and screen x
- cmd_height, cmd_y  in  H = clog2(FB_HEIGHT)+2 (10)  excerpt height and screen y
- cmd_clear_color  in  16  clear colour
- flush  in  1  synchronous discard of queued, unissued commands
- gpu_busy  in  1  GPU busy flag
- ctrl_address … ctrl_clear_color  out  same widths as cmd_*  GPU parameter bus
- ctrl_draw, ctrl_clear  out  1  GPU command strobes
- count  out  clog2(DEPTH)+1  queued entries, including the in-flight entry
- idle  out  1  queue empty and FSM in IDLE
- timeout_err  out  1  sticky: GPU never raised busy

Function
REQ-003 SHALL accept a command on a rising clk edge where cmd_valid && cmd_ready, and store all cmd_* fields in a DEPTH-entry FIFO.
REQ-004 SHALL drive cmd_ready = (count < DEPTH), combinationally from count only; a pop SHALL NOT bypass into a same-cycle push when full.
REQ-005 SHALL leave count unchanged on a simultaneous push and pop; pointers SHALL wrap modulo DEPTH.
REQ-006 SHALL implement FSM states IDLE, SETUP, PULSE, WAIT_BUSY, WAIT_DONE.
REQ-007 IDLE -> SETUP when count > 0 && !gpu_busy && !flush; otherwise stay in IDLE.
REQ-008 SETUP (1 cycle): ctrl_* fields SHALL equal the FIFO head entry; both strobes SHALL be low; next state PULSE.
REQ-009 PULSE (1 cycle): the head's type SHALL select the strobe, ctrl_draw=1 for a draw or ctrl_clear=1 for a clear; fields SHALL be held; next state WAIT_BUSY.
REQ-010 WAIT_BUSY: strobes low; -> WAIT_DONE when gpu_busy=1; if BUSY_TIMEOUT cycles elapse without busy, SHALL set timeout_err and -> WAIT_DONE.
REQ-011 WAIT_DONE: -> IDLE when gpu_busy=0, popping the head on that edge.
REQ-012 ctrl_* fields SHALL hold the issued values from SETUP until the pop edge, then hold the last values until the next SETUP.
REQ-013 Strobe timing: a push into an empty queue with the GPU idle SHALL give SETUP in the next cycle and a strobe 2 cycles after the accepting edge; each strobe SHALL be high for exactly 1 cycle.
REQ-014 There SHALL be at least 2 low cycles (IDLE, SETUP) between consecutive strobes.
REQ-015 flush SHALL discard all entries except one in SETUP through WAIT_DONE, which SHALL complete normally; count after flush is 0 or 1.
REQ-016 A flush coincident with a push SHALL win: the pushed command is discarded.
REQ-017 idle = (count==0 && state==IDLE).
REQ-018 timeout_err SHALL clear only on reset.

Reset
REQ-019 rstn=0 SHALL asynchronously force: state IDLE, pointers and count 0, all ctrl_* 0, strobes 0, timeout_err 0, idle 1, cmd_ready 1.
REQ-020 After a reset during an operation, the FSM SHALL not issue until gpu_busy=0 (see REQ-007).

Verification
REQ-021 Single draw: push draw (x=10, y=20, width=16, height=8, address=0x1000) into empty queue, GPU model busy for 128 cycles -> ctrl_draw high 1 cycle, 2 cycles after the accept edge; fields stable from SETUP to pop; count 1->0; idle=1 after.
REQ-022 Fill: push 5 commands back-to-back with GPU held busy -> 4 accepted, cmd_ready=0 at count=4; strobes issue in FIFO order with ≥2 low cycles between them.
REQ-023 Clear: push clear with colour 0xF801 -> ctrl_clear pulse, ctrl_draw stays 0, ctrl_clear_color=0xF801 held until busy falls.
REQ-024 Flush: 3 queued, head in WAIT_DONE, flush with a simultaneous push -> count=1, in-flight command completes, no further strobes.
REQ-025 Timeout: GPU model never raises busy -> timeout_err=1 exactly 4 cycles after the strobe; entry popped; queue continues.
REQ-026 Reset mid-op: rstn low during WAIT_DONE while gpu_busy=1 -> outputs 0 immediately; after release no strobe until gpu_busy=0.
